// File: rtl/axi_node_pkg.sv
// -----------------------------------------------------------------------------
// axi_node_pkg
// Shared definitions for the AXI node write-path blocks.
//   DEFAULT_N_SLAVE_PORT  : default number of write requesters on one node
//   DEFAULT_FIFO_DEPTH_DW : default number of AW grants that may be waiting for
//                           their W bursts to finish
//   sel_idx_t             : requester select index at the default port count
//   aw_lock_e             : whether the AW grant is held while the master
//                           port stalls
//   wrap_inc              : modulo increment used for round-robin and FIFO
//                           pointers
// -----------------------------------------------------------------------------
package axi_node_pkg;

  localparam int DEFAULT_N_SLAVE_PORT  = 4;
  localparam int DEFAULT_FIFO_DEPTH_DW = 4;

  typedef logic [$clog2(DEFAULT_N_SLAVE_PORT)-1:0] sel_idx_t;

  typedef enum logic {
    AW_OPEN   = 1'b0,
    AW_LOCKED = 1'b1
  } aw_lock_e;

  // Advance an index by one, wrapping back to zero at the modulus.
  function automatic int wrap_inc(input int value, input int modulus);
    return (value + 1 >= modulus) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/axi_node_order_fifo.sv
// -----------------------------------------------------------------------------
// axi_node_order_fifo
// Small FIFO that remembers the order in which AW requests were granted, so
// the W channel can be routed to the same requesters in the same order.
//   clk, rst  : clock and asynchronous active-high reset (empties the FIFO)
//   push      : store data_in at the tail (ignored when full)
//   pop       : drop the head entry (ignored when empty)
//   data_in   : requester index to store
//   data_out  : requester index at the head
//   full      : occupancy equals DEPTH (taken from the registered counter)
//   empty     : occupancy is zero
// -----------------------------------------------------------------------------
module axi_node_order_fifo
  import axi_node_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH_DW,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // Full/empty come straight from the registered occupancy, so a pop in the
  // same cycle never makes room for a push until the next cycle.
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign data_out = mem[rd_ptr_q];

  // Pointers wrap at DEPTH rather than at a power of two, so odd depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return PTR_W'(wrap_inc(int'(ptr), DEPTH));
  endfunction

  // Pointer and occupancy bookkeeping; a simultaneous push and pop moves both
  // pointers and leaves the count alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while the count says they
  // hold valid data.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: rtl/axi_node_wr_arbiter.sv
// -----------------------------------------------------------------------------
// axi_node_wr_arbiter
// Shares one master-side AXI write channel between N_SLAVE_PORT requesters.
// AW requests are arbitrated round-robin and each grant index is queued in an
// order FIFO; W beats are then routed from whichever requester sits at the
// FIFO head until its last beat is accepted.
//   clk, rst             : clock and asynchronous active-high reset
//   aw_valid_i/aw_ready_o: per-requester AW handshake
//   aw_valid_o/aw_ready_i: master-side AW handshake
//   aw_sel_o             : requester index steering the external AW payload mux
//   w_valid_i/w_last_i   : per-requester W valid and last
//   w_ready_o            : per-requester W ready
//   w_valid_o/w_last_o   : master-side W valid and last
//   w_ready_i            : master-side W ready
//   w_sel_o              : requester index steering the external W payload mux
// -----------------------------------------------------------------------------
module axi_node_wr_arbiter
  import axi_node_pkg::*;
#(
  parameter int N_SLAVE_PORT  = DEFAULT_N_SLAVE_PORT,
  parameter int FIFO_DEPTH_DW = DEFAULT_FIFO_DEPTH_DW,
  parameter int SEL_W         = $clog2(N_SLAVE_PORT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SLAVE_PORT-1:0] aw_valid_i,
  output logic [N_SLAVE_PORT-1:0] aw_ready_o,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [SEL_W-1:0]        aw_sel_o,
  input  logic [N_SLAVE_PORT-1:0] w_valid_i,
  input  logic [N_SLAVE_PORT-1:0] w_last_i,
  output logic [N_SLAVE_PORT-1:0] w_ready_o,
  output logic                    w_valid_o,
  output logic                    w_last_o,
  input  logic                    w_ready_i,
  output logic [SEL_W-1:0]        w_sel_o
);

  logic [SEL_W-1:0] rr_q;
  logic [SEL_W-1:0] lock_sel_q;
  aw_lock_e         lock_q;

  logic [SEL_W-1:0] rr_winner;
  logic [SEL_W-1:0] rr_cand;
  logic [SEL_W-1:0] aw_sel;
  logic             aw_req;
  logic             aw_hs;

  logic [SEL_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             w_pop;

  // Round-robin search: walk the requesters from the highest offset down to
  // rr_q itself so that the last hit, which is the one kept, is the first
  // asserted request at or after rr_q.
  always_comb begin
    rr_winner = '0;
    rr_cand   = '0;
    for (int i = N_SLAVE_PORT - 1; i >= 0; i--) begin
      rr_cand = SEL_W'((int'(rr_q) + i) % N_SLAVE_PORT);
      if (aw_valid_i[rr_cand]) begin
        rr_winner = rr_cand;
      end
    end
  end

  // While the master stalls a presented AW, the grant is frozen on the locked
  // requester so the external payload mux cannot switch under a pending
  // handshake. Reset forces every master-facing output low immediately,
  // even though requesters may still be driving valid.
  always_comb begin
    aw_sel     = (lock_q == AW_LOCKED) ? lock_sel_q : rr_winner;
    aw_req     = (lock_q == AW_LOCKED) ? aw_valid_i[lock_sel_q] : |aw_valid_i;
    aw_valid_o = !rst && !fifo_full && aw_req;
    aw_sel_o   = rst ? '0 : aw_sel;
    aw_hs      = aw_valid_o && aw_ready_i;
    aw_ready_o = '0;
    for (int k = 0; k < N_SLAVE_PORT; k++) begin
      aw_ready_o[k] = aw_hs && (aw_sel == SEL_W'(k));
    end
  end

  // The W channel only ever talks to the requester at the FIFO head; an entry
  // becomes visible one cycle after its AW handshake because the FIFO has no
  // bypass path.
  always_comb begin
    w_sel_o   = fifo_empty ? '0 : fifo_head;
    w_valid_o = !fifo_empty && w_valid_i[fifo_head];
    w_last_o  = w_valid_o && w_last_i[fifo_head];
    w_pop     = w_valid_o && w_ready_i && w_last_o;
    w_ready_o = '0;
    for (int k = 0; k < N_SLAVE_PORT; k++) begin
      w_ready_o[k] = w_ready_i && !fifo_empty && (fifo_head == SEL_W'(k));
    end
  end

  // Arbitration state: a completed handshake moves the round-robin pointer
  // past the winner and releases the lock; a presented but stalled request
  // captures the lock. A full FIFO keeps aw_valid_o low, so neither branch
  // fires and the state simply holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= '0;
      lock_q     <= AW_OPEN;
      lock_sel_q <= '0;
    end else if (aw_hs) begin
      rr_q   <= SEL_W'(wrap_inc(int'(aw_sel), N_SLAVE_PORT));
      lock_q <= AW_OPEN;
    end else if (aw_valid_o) begin
      lock_q     <= AW_LOCKED;
      lock_sel_q <= aw_sel;
    end
  end

  axi_node_order_fifo #(
    .DEPTH (FIFO_DEPTH_DW),
    .WIDTH (SEL_W)
  ) u_order_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (aw_hs),
    .pop      (w_pop),
    .data_in  (aw_sel),
    .data_out (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_axi_node_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_node_wr_arbiter
// Directed scenarios followed by a randomized back-pressure run. A reference
// model of the arbiter keeps its own queue of expected grant order; each
// grant is pushed when the bench sees the AW handshake and popped when the
// last W beat for it leaves the master port.
// -----------------------------------------------------------------------------
module tb_axi_node_wr_arbiter;
  import axi_node_pkg::*;

  localparam int N = 4;
  localparam int D = 4;
  localparam int N_BURSTS = 1000;

  typedef struct {
    sel_idx_t idx;
    int       len;
  } ord_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] aw_valid_i;
  logic [N-1:0] aw_ready_o;
  logic         aw_valid_o;
  logic         aw_ready_i;
  sel_idx_t     aw_sel_o;
  logic [N-1:0] w_valid_i;
  logic [N-1:0] w_last_i;
  logic [N-1:0] w_ready_o;
  logic         w_valid_o;
  logic         w_last_o;
  logic         w_ready_i;
  sel_idx_t     w_sel_o;

  int total = 0;
  int bad   = 0;

  // Reference model state and the scoreboard of expected W order.
  ord_t     ord_q[$];
  sel_idx_t rr_m;
  bit       locked_m;
  sel_idx_t lock_sel_m;
  bit       aw_exp_v;
  sel_idx_t aw_exp_sel;
  sel_idx_t head_m;
  bit       aw_hs_m;
  bit       w_hs_m;
  bit       pop_m;
  int       push_len[N];
  int       bcnt[N];
  int       mbeats;
  int       sbeats;

  axi_node_wr_arbiter #(
    .N_SLAVE_PORT  (N),
    .FIFO_DEPTH_DW (D),
    .SEL_W         (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .aw_valid_i (aw_valid_i),
    .aw_ready_o (aw_ready_o),
    .aw_valid_o (aw_valid_o),
    .aw_ready_i (aw_ready_i),
    .aw_sel_o   (aw_sel_o),
    .w_valid_i  (w_valid_i),
    .w_last_i   (w_last_i),
    .w_ready_o  (w_ready_o),
    .w_valid_o  (w_valid_o),
    .w_last_o   (w_last_o),
    .w_ready_i  (w_ready_i),
    .w_sel_o    (w_sel_o)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // One comparison: counted, and reported with tag, observed and expected.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive every requester- and master-side input in one go.
  task automatic applyStimulus(input logic [N-1:0] aw_v, input logic aw_r,
                               input logic [N-1:0] w_v, input logic [N-1:0] w_l,
                               input logic w_r);
    aw_valid_i = aw_v;
    aw_ready_i = aw_r;
    w_valid_i  = w_v;
    w_last_i   = w_l;
    w_ready_i  = w_r;
  endtask

  // First asserted request at or after the start index, wrapping around.
  function automatic sel_idx_t rrPick(input sel_idx_t start, input logic [N-1:0] v);
    sel_idx_t idx;
    for (int i = 0; i < N; i++) begin
      idx = sel_idx_t'((int'(start) + i) % N);
      if (v[idx]) return idx;
    end
    return '0;
  endfunction

  task automatic modelReset();
    ord_q.delete();
    rr_m       = '0;
    locked_m   = 1'b0;
    lock_sel_m = '0;
    aw_hs_m    = 1'b0;
    w_hs_m     = 1'b0;
    pop_m      = 1'b0;
  endtask

  // On the falling edge, compare every output against the model and work out
  // which handshakes the coming rising edge will perform.
  task automatic modelCheck();
    bit           full_m;
    bit           empty_m;
    bit           req_m;
    bit           w_exp_v;
    logic [N-1:0] exp_aw_r;
    logic [N-1:0] exp_w_r;
    @(negedge clk);
    full_m     = (ord_q.size() == D);
    empty_m    = (ord_q.size() == 0);
    aw_exp_sel = locked_m ? lock_sel_m : rrPick(rr_m, aw_valid_i);
    req_m      = locked_m ? aw_valid_i[lock_sel_m] : (aw_valid_i != '0);
    aw_exp_v   = !full_m && req_m;
    exp_aw_r   = '0;
    if (aw_exp_v && aw_ready_i) exp_aw_r[aw_exp_sel] = 1'b1;
    checkOutput("aw_valid", aw_valid_o, aw_exp_v);
    if (aw_exp_v) checkOutput("aw_sel", aw_sel_o, aw_exp_sel);
    checkOutput("aw_ready", aw_ready_o, exp_aw_r);
    head_m  = empty_m ? sel_idx_t'(0) : ord_q[0].idx;
    w_exp_v = !empty_m && w_valid_i[head_m];
    exp_w_r = '0;
    if (!empty_m && w_ready_i) exp_w_r[head_m] = 1'b1;
    checkOutput("w_valid", w_valid_o, w_exp_v);
    checkOutput("w_sel", w_sel_o, head_m);
    checkOutput("w_last", w_last_o, w_exp_v && w_last_i[head_m]);
    checkOutput("w_ready", w_ready_o, exp_w_r);
    aw_hs_m = aw_exp_v && aw_ready_i;
    w_hs_m  = w_exp_v && w_ready_i;
    pop_m   = w_hs_m && w_last_i[head_m];
    if (w_valid_o && w_ready_i) mbeats++;
    for (int k = 0; k < N; k++) begin
      if (w_valid_i[sel_idx_t'(k)] && w_ready_o[sel_idx_t'(k)]) sbeats++;
    end
  endtask

  // Just after the rising edge, commit the handshakes predicted above.
  task automatic modelAdvance();
    @(posedge clk);
    #1;
    if (pop_m) void'(ord_q.pop_front());
    if (aw_hs_m) begin
      ord_q.push_back('{aw_exp_sel, push_len[aw_exp_sel]});
      rr_m     = (aw_exp_sel == sel_idx_t'(N - 1)) ? '0 : aw_exp_sel + sel_idx_t'(1);
      locked_m = 1'b0;
    end else if (aw_exp_v) begin
      locked_m   = 1'b1;
      lock_sel_m = aw_exp_sel;
    end
  endtask

  // Directed scenarios first, then the randomized ordering run, then summary.
  initial begin
    int           drain1[4];
    int           issued;
    int           exp_beats;
    int           pending;
    int           len;
    bit           found;
    logic [N-1:0] lastv;

    drain1 = '{1, 2, 3, 0};
    for (int k = 0; k < N; k++) begin
      push_len[k] = 0;
      bcnt[k]     = 0;
    end
    mbeats = 0;
    sbeats = 0;

    // Reset with every requester asking: all outputs must stay low.
    rst = 1'b1;
    applyStimulus(4'hF, 1'b1, 4'hF, 4'hF, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_aw_valid", aw_valid_o, 0);
    checkOutput("rst_aw_ready", aw_ready_o, 0);
    checkOutput("rst_aw_sel", aw_sel_o, 0);
    checkOutput("rst_w_valid", w_valid_o, 0);
    checkOutput("rst_w_ready", w_ready_o, 0);
    rst = 1'b0;
    modelReset();
    $display("[TB] reset released");

    // All four requesting with the master ready: grants 0..3 fill the FIFO.
    applyStimulus(4'hF, 1'b1, 4'h0, 4'h0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      modelCheck();
      checkOutput("fill_grant", aw_sel_o, c);
      checkOutput("fill_aw_valid", aw_valid_o, 1);
      modelAdvance();
    end
    modelCheck();
    checkOutput("full_aw_valid", aw_valid_o, 0);
    checkOutput("full_aw_ready", aw_ready_o, 0);
    modelAdvance();

    // Last-beat pop while full: AW stays blocked this cycle, granted next.
    applyStimulus(4'hF, 1'b1, 4'b0001, 4'b0001, 1'b1);
    modelCheck();
    checkOutput("popfull_aw_blocked", aw_valid_o, 0);
    checkOutput("popfull_w_last", w_last_o, 1);
    modelAdvance();
    applyStimulus(4'hF, 1'b1, 4'h0, 4'h0, 1'b1);
    modelCheck();
    checkOutput("popfull_aw_valid", aw_valid_o, 1);
    checkOutput("popfull_aw_sel", aw_sel_o, 0);
    modelAdvance();

    // Drain single-beat bursts in grant order.
    applyStimulus(4'h0, 1'b0, 4'hF, 4'hF, 1'b1);
    for (int c = 0; c < 4; c++) begin
      modelCheck();
      checkOutput("drain_w_sel", w_sel_o, drain1[c]);
      modelAdvance();
    end
    modelCheck();
    checkOutput("empty_w_valid", w_valid_o, 0);
    checkOutput("empty_w_ready", w_ready_o, 0);
    modelAdvance();

    // Grant requester 3 so the pointer wraps to 0, then retire its burst.
    applyStimulus(4'b1000, 1'b1, 4'h0, 4'h0, 1'b0);
    modelCheck();
    checkOutput("wrap_aw_sel", aw_sel_o, 3);
    modelAdvance();
    applyStimulus(4'h0, 1'b0, 4'b1000, 4'b1000, 1'b1);
    modelCheck();
    checkOutput("wrap_w_sel", w_sel_o, 3);
    modelAdvance();

    // Requester 2 stalled by the master; requester 0 joins but the lock holds.
    applyStimulus(4'b0100, 1'b0, 4'h0, 4'h0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      modelCheck();
      checkOutput("lock_aw_sel", aw_sel_o, 2);
      modelAdvance();
    end
    applyStimulus(4'b0101, 1'b0, 4'h0, 4'h0, 1'b0);
    modelCheck();
    checkOutput("lock_hold_sel", aw_sel_o, 2);
    checkOutput("lock_hold_ready", aw_ready_o, 0);
    modelAdvance();
    applyStimulus(4'b0101, 1'b1, 4'h0, 4'h0, 1'b0);
    modelCheck();
    checkOutput("lock_hs_sel", aw_sel_o, 2);
    checkOutput("lock_hs_ready", aw_ready_o, 4'b0100);
    modelAdvance();
    applyStimulus(4'b0001, 1'b1, 4'h0, 4'h0, 1'b0);
    modelCheck();
    checkOutput("lock_next_sel", aw_sel_o, 0);
    modelAdvance();
    applyStimulus(4'h0, 1'b0, 4'b0101, 4'b0101, 1'b1);
    modelCheck();
    checkOutput("lock_drain0", w_sel_o, 2);
    modelAdvance();
    modelCheck();
    checkOutput("lock_drain1", w_sel_o, 0);
    modelAdvance();

    // Grants to 1 then 3; requester 3 waits behind requester 1's 4-beat burst.
    applyStimulus(4'b0010, 1'b1, 4'h0, 4'h0, 1'b0);
    modelCheck();
    checkOutput("order_aw1", aw_sel_o, 1);
    modelAdvance();
    applyStimulus(4'b1000, 1'b1, 4'b1000, 4'h0, 1'b1);
    modelCheck();
    checkOutput("order_aw3", aw_sel_o, 3);
    checkOutput("order_w_wait", w_valid_o, 0);
    modelAdvance();
    applyStimulus(4'h0, 1'b0, 4'b1000, 4'h0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      modelCheck();
      checkOutput("order_blocked_valid", w_valid_o, 0);
      checkOutput("order_blocked_ready", w_ready_o, 4'b0010);
      modelAdvance();
    end
    for (int b = 0; b < 4; b++) begin
      lastv = (b == 3) ? 4'b0010 : 4'b0000;
      applyStimulus(4'h0, 1'b0, 4'b1010, lastv, 1'b1);
      modelCheck();
      checkOutput("order_r1_sel", w_sel_o, 1);
      checkOutput("order_r1_last", w_last_o, (b == 3));
      modelAdvance();
    end
    for (int b = 0; b < 2; b++) begin
      lastv = (b == 1) ? 4'b1000 : 4'b0000;
      applyStimulus(4'h0, 1'b0, 4'b1000, lastv, 1'b1);
      modelCheck();
      checkOutput("order_r3_sel", w_sel_o, 3);
      checkOutput("order_r3_valid", w_valid_o, 1);
      modelAdvance();
    end

    // Reset pulsed during beat 2 of a 4-beat burst from requester 1.
    applyStimulus(4'b0010, 1'b1, 4'h0, 4'h0, 1'b0);
    modelCheck();
    checkOutput("mid_aw_sel", aw_sel_o, 1);
    modelAdvance();
    applyStimulus(4'h0, 1'b0, 4'b0010, 4'h0, 1'b1);
    modelCheck();
    checkOutput("mid_beat1", w_valid_o, 1);
    modelAdvance();
    applyStimulus(4'b0100, 1'b1, 4'b0010, 4'h0, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_aw_valid", aw_valid_o, 0);
    checkOutput("mid_rst_aw_ready", aw_ready_o, 0);
    checkOutput("mid_rst_aw_sel", aw_sel_o, 0);
    checkOutput("mid_rst_w_valid", w_valid_o, 0);
    checkOutput("mid_rst_w_last", w_last_o, 0);
    checkOutput("mid_rst_w_ready", w_ready_o, 0);
    checkOutput("mid_rst_w_sel", w_sel_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    applyStimulus(4'b0110, 1'b0, 4'b0010, 4'b0010, 1'b1);
    modelCheck();
    checkOutput("post_rst_w_valid", w_valid_o, 0);
    checkOutput("post_rst_w_ready", w_ready_o, 0);
    checkOutput("post_rst_grant", aw_sel_o, 1);
    modelAdvance();
    applyStimulus(4'b0010, 1'b1, 4'h0, 4'h0, 1'b0);
    modelCheck();
    checkOutput("post_rst_hs_sel", aw_sel_o, 1);
    modelAdvance();
    applyStimulus(4'h0, 1'b0, 4'b0010, 4'b0010, 1'b1);
    modelCheck();
    checkOutput("post_rst_w_sel", w_sel_o, 1);
    modelAdvance();
    applyStimulus(4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
    $display("[TB] directed scenarios complete, starting random run");

    // Random requesters with random burst lengths and master back-pressure.
    issued    = 0;
    exp_beats = 0;
    mbeats    = 0;
    sbeats    = 0;
    for (int k = 0; k < N; k++) bcnt[k] = 0;
    for (int cyc = 0; cyc < 60000; cyc++) begin
      if (issued >= N_BURSTS && aw_valid_i == '0 && ord_q.size() == 0) break;
      modelCheck();
      modelAdvance();
      if (aw_hs_m) aw_valid_i[aw_exp_sel] = 1'b0;
      if (w_hs_m) bcnt[head_m]++;
      if (pop_m) bcnt[head_m] = 0;
      for (int k = 0; k < N; k++) begin
        if (!aw_valid_i[sel_idx_t'(k)] && issued < N_BURSTS && $urandom_range(0, 3) == 0) begin
          aw_valid_i[sel_idx_t'(k)] = 1'b1;
          push_len[k] = int'($urandom_range(1, 4));
          exp_beats += push_len[k];
          issued++;
        end
        found = 1'b0;
        len   = 0;
        for (int e = 0; e < ord_q.size(); e++) begin
          if (!found && ord_q[e].idx == sel_idx_t'(k)) begin
            found = 1'b1;
            len   = ord_q[e].len;
          end
        end
        w_valid_i[sel_idx_t'(k)] = found && ($urandom_range(0, 2) != 0);
        w_last_i[sel_idx_t'(k)]  = found && (bcnt[k] == len - 1);
      end
      aw_ready_i = ($urandom_range(0, 1) == 1);
      w_ready_i  = ($urandom_range(0, 3) != 0);
    end
    pending = ord_q.size() + $countones(aw_valid_i);
    checkOutput("rnd_pending", pending, 0);
    checkOutput("rnd_issued", issued, N_BURSTS);
    checkOutput("rnd_master_beats", mbeats, exp_beats);
    checkOutput("rnd_slave_beats", sbeats, exp_beats);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
